// File: rtl/mw8080_mem_pkg.sv
// Shared types and constants for the Midway-Taito 8080 memory subsystem.
// Holds the FSM state and address-region encodings and the unmapped read value.
package mw8080_mem_pkg;

    typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

    typedef enum logic [1:0] {ROM, RAM, UNMAPPED} region_t;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/mw8080_ram_arb.sv
// Work/video RAM with fixed-priority video-over-CPU arbitration, pending CPU latch and clear mux.
// Reads complete one cycle after grant; a CPU request blocked by video is held until vid_req drops.
module mw8080_ram_arb #(
    parameter int RAM_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr_en,
    input  logic [RAM_AW-1:0] clr_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              vid_req,
    input  logic [RAM_AW-1:0] vid_addr,
    output logic [7:0]        vid_dout,
    output logic              vid_valid,
    output logic              cpu_gnt,
    output logic              cpu_gnt_we,
    output logic [7:0]        cpu_rdat,
    output logic              cpu_wait,
    output logic              cpu_pend
);

    logic [7:0]        mem [2**RAM_AW];
    logic              pend_vld;
    logic              pend_we;
    logic [RAM_AW-1:0] pend_addr;
    logic [7:0]        pend_dat;

    logic              req_vld;
    logic              req_we;
    logic [RAM_AW-1:0] req_addr;
    logic [7:0]        req_dat;
    logic              vid_gnt;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdat;

    // A latched request takes precedence; new strobes are gated off upstream while one is pending.
    always_comb begin
        req_vld    = pend_vld | cpu_req;
        req_we     = pend_vld ? pend_we   : cpu_we;
        req_addr   = pend_vld ? pend_addr : cpu_addr;
        req_dat    = pend_vld ? pend_dat  : cpu_din;
        vid_gnt    = run & vid_req;
        cpu_gnt    = run & req_vld & ~vid_req;
        cpu_gnt_we = cpu_gnt & req_we;
        cpu_wait   = run & req_vld & vid_req;
        ram_we     = 1'b0;
        ram_addr   = vid_addr;
        ram_wdat   = 8'h00;
        if (clr_en) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (cpu_gnt) begin
            ram_we   = req_we;
            ram_addr = req_addr;
            ram_wdat = req_dat;
        end
    end

    assign cpu_rdat = mem[ram_addr];
    assign cpu_pend = pend_vld;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_dat  <= 8'h00;
            vid_valid <= 1'b0;
            vid_dout  <= 8'h00;
        end else begin
            vid_valid <= vid_gnt;
            if (vid_gnt) vid_dout <= cpu_rdat;
            if (!run || cpu_gnt) begin
                pend_vld <= 1'b0;
            end else if (cpu_req && vid_req) begin
                pend_vld  <= 1'b1;
                pend_we   <= cpu_we;
                pend_addr <= cpu_addr;
                pend_dat  <= cpu_din;
            end
        end
    end

endmodule

// File: rtl/mw8080_mem_subsys.sv
// Banked loadable ROM plus shared work/video RAM for the 8080 core, with clear/load sequencing.
// CPU and video data return one cycle after grant; CPU stalls only on RAM collisions with video.
module mw8080_mem_subsys
    import mw8080_mem_pkg::*;
#(
    parameter int          ROM_BANKS = 4,
    parameter int          ROM_AW    = 10,
    parameter int          RAM_AW    = 13,
    parameter logic [15:0] RAM_BASE  = 16'h2000,
    parameter int          DL_AW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_valid,
    output logic              cpu_wait,
    input  logic              vid_req,
    input  logic [RAM_AW-1:0] vid_addr,
    output logic [7:0]        vid_dout,
    output logic              vid_valid,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [DL_AW-1:0]  dl_addr,
    input  logic [7:0]        dl_data,
    output logic              ready
);

    localparam int             ROM_BYTES = ROM_BANKS << ROM_AW;
    localparam logic [16:0]    CPU_LIMIT = 17'(ROM_BYTES);
    localparam logic [DL_AW:0] DL_LIMIT  = (DL_AW+1)'(ROM_BYTES);

    state_t            state;
    logic [RAM_AW-1:0] clr_cnt;
    region_t           region;
    logic              run;
    logic              acc;
    logic              ram_req;
    logic              cpu_gnt;
    logic              cpu_gnt_we;
    logic [7:0]        ram_rdat;
    logic              ram_wait;
    logic              ram_pend;
    logic              dl_hit;
    logic [2:0]        cpu_bank;
    logic [2:0]        dl_bank;
    logic [7:0]        rom_rd [8];

    always_comb begin
        if ({1'b0, cpu_addr} < CPU_LIMIT)
            region = ROM;
        else if (cpu_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW])
            region = RAM;
        else
            region = UNMAPPED;
    end

    assign run      = (state == RUN);
    assign acc      = run & (cpu_rd | cpu_wr) & ~ram_pend;
    assign ram_req  = acc & (region == RAM);
    assign cpu_wait = ~run | ram_wait;
    assign cpu_bank = cpu_addr[ROM_AW +: 3];
    assign dl_bank  = dl_addr[ROM_AW +: 3];
    assign dl_hit   = (state == LOAD) & dl_wr & ({1'b0, dl_addr} < DL_LIMIT);

    // Unpopulated bank slots read as zero; the region decode never selects them.
    for (genvar b = 0; b < 8; b++) begin : g_rom
        if (b < ROM_BANKS) begin : g_bank
            logic [7:0] mem [2**ROM_AW];
            always_ff @(posedge clk) begin
                if (dl_hit && dl_bank == 3'(b)) mem[dl_addr[ROM_AW-1:0]] <= dl_data;
            end
            assign rom_rd[b] = mem[cpu_addr[ROM_AW-1:0]];
        end else begin : g_none
            assign rom_rd[b] = 8'h00;
        end
    end

    mw8080_ram_arb #(.RAM_AW(RAM_AW)) u_ram_arb (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .clr_en     (state == CLEAR),
        .clr_addr   (clr_cnt),
        .cpu_req    (ram_req),
        .cpu_we     (cpu_wr),
        .cpu_addr   (cpu_addr[RAM_AW-1:0]),
        .cpu_din    (cpu_din),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_dout   (vid_dout),
        .vid_valid  (vid_valid),
        .cpu_gnt    (cpu_gnt),
        .cpu_gnt_we (cpu_gnt_we),
        .cpu_rdat   (ram_rdat),
        .cpu_wait   (ram_wait),
        .cpu_pend   (ram_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            ready     <= 1'b0;
            cpu_valid <= 1'b0;
            cpu_dout  <= 8'h00;
        end else begin
            // ROM and unmapped accesses complete unconditionally; RAM completes on grant.
            cpu_valid <= (acc && region != RAM) || cpu_gnt;
            if (acc && region == ROM && !cpu_wr)
                cpu_dout <= rom_rd[cpu_bank];
            else if (acc && region == UNMAPPED && !cpu_wr)
                cpu_dout <= UNMAPPED_DATA;
            else if (cpu_gnt && !cpu_gnt_we)
                cpu_dout <= ram_rdat;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (dl_active) begin
                        state <= LOAD;
                        ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!dl_active) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mw8080_mem_subsys.sv
// Directed bench for mw8080_mem_subsys: clear timing, ROM load, RAM arbitration, decode, reset restart.
module tb_mw8080_mem_subsys;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_valid;
    logic        cpu_wait;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [7:0]  vid_dout;
    logic        vid_valid;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        ready;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    mw8080_mem_subsys dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_valid (cpu_valid),
        .cpu_wait  (cpu_wait),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_dout  (vid_dout),
        .vid_valid (vid_valid),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .ready     (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 20000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d);
        cpu_addr = a;
        cpu_rd   = rd;
        cpu_wr   = wr;
        cpu_din  = d;
        tick();
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        cpu_op(a, 1'b1, 1'b0, 8'h00);
        chk({tag, "_vld"}, cpu_valid, 1);
        chk(tag, cpu_dout, exp);
    endtask

    function automatic logic [7:0] rom_pat(input int i);
        logic [15:0] v;
        v = 16'(i);
        return (i == 12'hC05) ? 8'h5A : (v[7:0] ^ 8'hA5);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_din = '0;
        vid_req = 0; vid_addr = '0; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
        tick(); tick();

        chk("rst_cpu_valid", cpu_valid, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_ready",     ready,     0);
        chk("rst_cpu_wait",  cpu_wait,  1);
        chk("rst_cpu_dout",  cpu_dout,  0);
        chk("rst_vid_dout",  vid_dout,  0);

        rst = 1'b0;
        wait_ready(n);
        chk("clear_cycles", n, 8192);
        chk("run_wait", cpu_wait, 0);

        // Unmapped read first so the following RAM zero is a real change on cpu_dout.
        cpu_read_chk("unmapped_rd", 16'h5000, 8'hFF);
        cpu_read_chk("ram_cleared", 16'h2123, 8'h00);
        tick();
        chk("valid_pulse_1cyc", cpu_valid, 0);

        // ROM download, including an out-of-range offset that would alias bank 0.
        dl_active = 1'b1;
        tick();
        chk("load_ready", ready, 0);
        chk("load_wait", cpu_wait, 1);
        for (int i = 0; i < 4096; i++) begin
            dl_wr = 1'b1; dl_addr = 16'(i); dl_data = rom_pat(i);
            tick();
        end
        dl_addr = 16'h2005; dl_data = 8'hEE;
        tick();
        dl_wr = 1'b0;
        cpu_op(16'h0000, 1'b1, 1'b0, 8'h00);
        chk("load_cpu_ignored", cpu_valid, 0);
        vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        chk("load_vid_ignored", vid_valid, 0);
        dl_active = 1'b0;
        tick();
        wait_ready(n);
        chk("postload_clear_cycles", n, 8192);

        cpu_read_chk("rom_c05",  16'h0C05, 8'h5A);
        cpu_read_chk("rom_drop", 16'h0005, 8'hA0);
        cpu_read_chk("rom_3ff",  16'h03FF, 8'h5A);
        cpu_read_chk("rom_400",  16'h0400, 8'hA5);

        // CPU RAM write colliding with video for three cycles.
        vid_req = 1'b1; vid_addr = 13'h0400;
        cpu_addr = 16'h2400; cpu_wr = 1'b1; cpu_din = 8'h3C;
        #1;
        chk("coll_wait_c1", cpu_wait, 1);
        tick();
        cpu_wr = 1'b0;
        chk("coll_vid_valid", vid_valid, 1);
        chk("coll_vid_old", vid_dout, 8'h00);
        chk("coll_no_valid_c1", cpu_valid, 0);
        chk("coll_wait_c2", cpu_wait, 1);
        tick();
        chk("coll_wait_c3", cpu_wait, 1);
        chk("coll_no_valid_c3", cpu_valid, 0);
        tick();
        vid_req = 1'b0;
        #1;
        chk("coll_wait_c4", cpu_wait, 0);
        tick();
        chk("coll_done", cpu_valid, 1);
        vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        chk("vid_rd_vld", vid_valid, 1);
        chk("vid_rd_3c", vid_dout, 8'h3C);
        cpu_read_chk("cpu_rd_2400", 16'h2400, 8'h3C);

        // ROM access proceeds alongside a video read.
        vid_req = 1'b1; vid_addr = 13'h0400;
        cpu_addr = 16'h0C05; cpu_rd = 1'b1;
        #1;
        chk("rom_nostall_wait", cpu_wait, 0);
        tick();
        cpu_rd = 1'b0; vid_req = 1'b0;
        chk("rom_nostall_vld", cpu_valid, 1);
        chk("rom_nostall_dat", cpu_dout, 8'h5A);
        chk("rom_nostall_vid", vid_valid, 1);

        cpu_op(16'h0010, 1'b0, 1'b1, 8'h99);
        chk("rom_wr_valid", cpu_valid, 1);
        cpu_read_chk("rom_wr_dropped", 16'h0010, 8'hB5);

        cpu_op(16'h2401, 1'b1, 1'b1, 8'h42);
        chk("rdwr_valid", cpu_valid, 1);
        cpu_read_chk("rdwr_is_write", 16'h2401, 8'h42);

        // Reset part way through a clear.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("midclear_ready", ready, 0);
        chk("midclear_wait", cpu_wait, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        chk("restart_clear_cycles", n, 8192);
        cpu_read_chk("restart_ram_zero", 16'h2400, 8'h00);
        cpu_read_chk("restart_rom_kept", 16'h0C05, 8'h5A);

        // Download during RUN re-clears RAM and updates ROM.
        cpu_op(16'h2400, 1'b0, 1'b1, 8'h3C);
        cpu_op(16'h3FFF, 1'b0, 1'b1, 8'h11);
        cpu_read_chk("pre_ram_3fff", 16'h3FFF, 8'h11);
        dl_active = 1'b1;
        tick();
        dl_wr = 1'b1; dl_addr = 16'h0C05; dl_data = 8'hC3;
        tick();
        dl_wr = 1'b0; dl_active = 1'b0;
        tick();
        wait_ready(n);
        chk("reload_clear_cycles", n, 8192);
        cpu_read_chk("reload_ram_2400", 16'h2400, 8'h00);
        cpu_read_chk("reload_ram_3fff", 16'h3FFF, 8'h00);
        cpu_read_chk("reload_rom_c05",  16'h0C05, 8'hC3);
        cpu_read_chk("reload_rom_005",  16'h0005, 8'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
